param_transposed_fir: RTL and testbench

Parametrised transposed-form FIR filter, the next generation of the team's fixed 33-tap reconfigurable FIR. Tap count and data widths are generalised. A shadow/active coefficient bank pair lets new coefficients load while filtering continues, and they swap in atomically on a sample boundary. The block adds an explicit sample-enable, an output-valid strobe, coefficient readback, and rounding/scaling of the full-precision accumulator. It sits between the sample-rate input path and the downstream output stage, on the 12 MHz system clock.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/fir_coef_bank.sv | 73 +++++++
 rtl/param_transposed_fir.sv | 136 +++++++++++++
 tb/tb_param_transposed_fir.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the parametrised transposed-form FIR.
// Build option: define FIR_OUT_SAT_EN to clamp the output instead of wrapping.
package fir_pkg;

  // Coefficient bank control: idle, shadow load window open, swap pending.
  typedef enum logic [1:0] {StIdle, StLoad, StPend} coef_state_e;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

  // Full-precision accumulator width: one product plus headroom for every tap.
  function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned coef_w,
                                            input int unsigned taps);
    return in_w + coef_w + clog2(taps);
  endfunction

  // Round half up, then arithmetic shift; 64-bit working width avoids overflow on the bias add.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                     input int unsigned sh);
    if (sh == 0) return v;
    return (v + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

  // Clamp to the signed range of a w-bit value.
  function automatic logic signed [63:0] clamp(input logic signed [63:0] v,
                                               input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient banks: write into shadow, read back active,
// copy active->shadow when a load starts, shadow->active on swap.
module fir_coef_bank #(
  parameter int unsigned NUM_TAPS = 33,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load_start,
  input  logic                         swap,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [COEF_W-1:0]            wr_data,
  output logic [COEF_W-1:0]            rd_data,
  output logic [NUM_TAPS*COEF_W-1:0]   coef
);

  logic [COEF_W-1:0] shadow_q [NUM_TAPS];
  logic [COEF_W-1:0] shadow_d [NUM_TAPS];
  logic [COEF_W-1:0] active_q [NUM_TAPS];
  logic [COEF_W-1:0] active_d [NUM_TAPS];
  logic [COEF_W-1:0] rd_q;
  logic [COEF_W-1:0] rd_d;

  // Bank next state; a write in the load-start cycle overrides the copied value.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    rd_d     = rd_q;
    if (load_start) shadow_d = active_q;
    if (wr_en) begin
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        if (addr == ADDR_W'(k)) shadow_d[k] = wr_data;
      end
    end
    if (swap) active_d = shadow_q;
    // Out-of-range addresses match no tap and read back as zero.
    if (rd_en) begin
      rd_d = '0;
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        if (addr == ADDR_W'(k)) rd_d = active_q[k];
      end
    end
  end

  // Bank and readback registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(NUM_TAPS); k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      rd_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      rd_q     <= rd_d;
    end
  end

  // Coefficients seen by the datapath: the swap sample already uses the new set.
  always_comb begin
    coef = '0;
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      coef[k*COEF_W +: COEF_W] = swap ? shadow_q[k] : active_q[k];
    end
  end

  assign rd_data = rd_q;

endmodule

// File: rtl/param_transposed_fir.sv
// Parametrised transposed-form FIR with double-buffered coefficients.
// Build option: define FIR_OUT_SAT_EN to saturate the scaled output to OUT_W bits;
// otherwise the low OUT_W bits are kept (two's-complement wrap).
module param_transposed_fir
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS      = 33,
  parameter int unsigned IN_W          = 3,
  parameter int unsigned COEF_W        = 16,
  parameter int unsigned OUT_W         = 16,
  parameter int unsigned OUT_SHIFT     = 0,
  parameter int unsigned ADDR_W        = 6,
  parameter int unsigned FLUSH_ON_SWAP = 0
) (
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iEnSample,
  input  logic [IN_W-1:0]   iFirIn,
  input  logic              iCoeffiUpdateFlag,
  input  logic              iCsnRam,
  input  logic              iWrnRam,
  input  logic [ADDR_W-1:0] iAddrRam,
  input  logic [COEF_W-1:0] iWrDtRam,
  output logic [COEF_W-1:0] oRdDtRam,
  output logic              oCoeffBusy,
  output logic [OUT_W-1:0]  oFirOut,
  output logic              oFirValid
);

  localparam int unsigned ACC_W = acc_width(IN_W, COEF_W, NUM_TAPS);

  coef_state_e state_q, state_d;
  logic load_start, swap, flush, wr_en, rd_en;
  logic [NUM_TAPS*COEF_W-1:0] coef;

  // p[1..NUM_TAPS-1] of the transposed chain; entry j holds p[j+1].
  logic signed [ACC_W-1:0] pq_q  [NUM_TAPS-1];
  logic signed [ACC_W-1:0] pq_d  [NUM_TAPS-1];
  logic signed [ACC_W-1:0] old_p [NUM_TAPS-1];
  logic signed [ACC_W-1:0] prod  [NUM_TAPS];
  logic signed [ACC_W-1:0] x_ext, c_ext, y;
  logic signed [63:0]      y_wide;
  logic [OUT_W-1:0]        out_q, out_d;
  logic                    valid_q;

  assign wr_en = !iCsnRam && !iWrnRam && iCoeffiUpdateFlag;
  assign rd_en = !iCsnRam && iWrnRam;
  assign flush = (FLUSH_ON_SWAP != 0) && swap;

  // Coefficient FSM; a re-asserted flag while pending wins over the swap.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    swap       = 1'b0;
    unique case (state_q)
      StIdle: if (iCoeffiUpdateFlag) begin
        state_d    = StLoad;
        load_start = 1'b1;
      end
      StLoad: if (!iCoeffiUpdateFlag) state_d = StPend;
      StPend: begin
        if (iCoeffiUpdateFlag) begin
          state_d = StLoad;
        end else if (iEnSample) begin
          state_d = StIdle;
          swap    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .ADDR_W   (ADDR_W)
  ) u_bank (
    .clk        (iClk_12M),
    .rst_n      (iRsn),
    .load_start (load_start),
    .swap       (swap),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .addr       (iAddrRam),
    .wr_data    (iWrDtRam),
    .rd_data    (oRdDtRam),
    .coef       (coef)
  );

  // Products, transposed chain update and scaled output.
  always_comb begin
    x_ext = {{(ACC_W-IN_W){iFirIn[IN_W-1]}}, iFirIn};
    c_ext = '0;
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      c_ext   = {{(ACC_W-COEF_W){coef[k*COEF_W+COEF_W-1]}}, coef[k*COEF_W +: COEF_W]};
      prod[k] = x_ext * c_ext;
    end
    for (int j = 0; j < int'(NUM_TAPS) - 1; j++) begin
      old_p[j] = flush ? '0 : pq_q[j];
    end
    y = prod[0] + old_p[0];
    pq_d = pq_q;
    if (iEnSample) begin
      for (int j = 0; j < int'(NUM_TAPS) - 2; j++) begin
        pq_d[j] = prod[j+1] + old_p[j+1];
      end
      pq_d[NUM_TAPS-2] = prod[NUM_TAPS-1];
    end
    y_wide = {{(64-ACC_W){y[ACC_W-1]}}, y};
`ifdef FIR_OUT_SAT_EN
    out_d = iEnSample ? OUT_W'(clamp(round_shift(y_wide, OUT_SHIFT), OUT_W)) : out_q;
`else
    out_d = iEnSample ? OUT_W'(round_shift(y_wide, OUT_SHIFT)) : out_q;
`endif
  end

  // State, delay line and output registers.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= StIdle;
      for (int j = 0; j < int'(NUM_TAPS) - 1; j++) pq_q[j] <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pq_q    <= pq_d;
      out_q   <= out_d;
      valid_q <= iEnSample;
    end
  end

  assign oCoeffBusy = (state_q != StIdle);
  assign oFirOut    = out_q;
  assign oFirValid  = valid_q;

endmodule

// File: tb/tb_param_transposed_fir.sv
// Directed bench: impulse table, port rules, shadow swap, saturation/wrap,
// reset during load, plus a 2-tap OUT_SHIFT=2 instance for rounding.
module tb_param_transposed_fir;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance, default parameters.
  logic              en, flag, csn, wrn;
  logic signed [2:0] x;
  logic [5:0]        addr;
  logic [15:0]       wdata;
  logic signed [15:0] rdata, fir_out;
  logic              busy, valid;

  param_transposed_fir dut (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iEnSample         (en),
    .iFirIn            (x),
    .iCoeffiUpdateFlag (flag),
    .iCsnRam           (csn),
    .iWrnRam           (wrn),
    .iAddrRam          (addr),
    .iWrDtRam          (wdata),
    .oRdDtRam          (rdata),
    .oCoeffBusy        (busy),
    .oFirOut           (fir_out),
    .oFirValid         (valid)
  );

  // Rounding instance: two taps, shift by two.
  logic              r_en, r_flag, r_csn, r_wrn;
  logic signed [2:0] r_x;
  logic [0:0]        r_addr;
  logic [15:0]       r_wdata;
  logic [15:0]       r_rdata;
  logic signed [15:0] r_out;
  logic              r_busy, r_valid;

  param_transposed_fir #(
    .NUM_TAPS  (2),
    .OUT_SHIFT (2),
    .ADDR_W    (1)
  ) dut_r (
    .iClk_12M          (clk),
    .iRsn              (rst_n),
    .iEnSample         (r_en),
    .iFirIn            (r_x),
    .iCoeffiUpdateFlag (r_flag),
    .iCsnRam           (r_csn),
    .iWrnRam           (r_wrn),
    .iAddrRam          (r_addr),
    .iWrDtRam          (r_wdata),
    .oRdDtRam          (r_rdata),
    .oCoeffBusy        (r_busy),
    .oFirOut           (r_out),
    .oFirValid         (r_valid)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int exp;
  } vec_t;
  vec_t vecs[35];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    csn = 1'b0; wrn = 1'b0; addr = 6'(a); wdata = 16'(d);
    tick();
    csn = 1'b1; wrn = 1'b1;
  endtask

  task automatic rd(input int a, output int d);
    csn = 1'b0; wrn = 1'b1; addr = 6'(a);
    tick();
    csn = 1'b1;
    d = int'(rdata);
  endtask

  // One strobe; result is registered by the edge that ends this cycle.
  task automatic smp(input int v, output int y, output int vld);
    en = 1'b1; x = 3'(v);
    tick();
    en = 1'b0;
    y = int'(fir_out);
    vld = int'(valid);
  endtask

  task automatic smp_chk(input string name, input int v, input int exp);
    int y, vld;
    smp(v, y, vld);
    check({name, "_out"}, y, exp);
    check({name, "_valid"}, vld, 1);
  endtask

  // Load every tap with one value and complete the swap with an x=0 strobe.
  task automatic load_all(input int value);
    int y, vld;
    flag = 1'b1;
    tick();
    for (int k = 0; k < 33; k++) wr(k, value);
    flag = 1'b0;
    tick();
    smp(0, y, vld);
  endtask

  task automatic zeros(input int n);
    int y, vld;
    for (int i = 0; i < n; i++) smp(0, y, vld);
  endtask

  task automatic r_load(input int c0);
    r_flag = 1'b1;
    tick();
    r_csn = 1'b0; r_wrn = 1'b0; r_addr = 1'b0; r_wdata = 16'(c0);
    tick();
    r_csn = 1'b1; r_wrn = 1'b1; r_flag = 1'b0;
    tick();
    r_en = 1'b1; r_x = 3'sd0;
    tick();
    r_en = 1'b0;
  endtask

  task automatic r_chk(input string name, input int v, input int exp);
    r_en = 1'b1; r_x = 3'(v);
    tick();
    r_en = 1'b0;
    check({name, "_out"}, int'(r_out), exp);
    check({name, "_valid"}, int'(r_valid), 1);
  endtask

  initial begin
    int d, y, vld;
    rst_n = 1'b0;
    en = 1'b0; flag = 1'b0; csn = 1'b1; wrn = 1'b1; x = '0; addr = '0; wdata = '0;
    r_en = 1'b0; r_flag = 1'b0; r_csn = 1'b1; r_wrn = 1'b1; r_x = '0; r_addr = '0;
    r_wdata = '0;

    // Impulse table: x=1 then zeros gives the coefficients 1..33, then 0.
    vecs[0] = '{x: 1, exp: 1};
    for (int i = 1; i < 35; i++) vecs[i] = '{x: 0, exp: (i <= 32) ? i + 1 : 0};

    tick(); tick();
    check("rst_out", int'(fir_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd", int'(rdata), 0);
    rst_n = 1'b1;
    tick();

    // Load 1..33, plus an out-of-range write that must be dropped.
    flag = 1'b1;
    tick();
    check("busy_load", int'(busy), 1);
    for (int k = 0; k < 33; k++) wr(k, k + 1);
    wr(40, 16'h1234);
    flag = 1'b0;
    tick();
    check("busy_pend", int'(busy), 1);
    rd(5, d);
    check("rd_before_swap", d, 0);
    smp_chk("swap0", 0, 0);
    check("busy_after_swap", int'(busy), 0);
    rd(5, d);
    check("rd_tap5", d, 6);
    rd(32, d);
    check("rd_tap32", d, 33);
    rd(40, d);
    check("rd_addr40", d, 0);

    for (int i = 0; i < 35; i++) smp_chk($sformatf("imp%0d", i), vecs[i].x, vecs[i].exp);

    // Valid is a single-cycle strobe and the output holds.
    smp_chk("hold_src", 1, 1);
    tick();
    check("hold_valid", int'(valid), 0);
    check("hold_out", int'(fir_out), 1);

    // Write with the flag low is ignored and does not start a load.
    csn = 1'b0; wrn = 1'b0; addr = 6'd5; wdata = 16'h0777;
    tick();
    csn = 1'b1; wrn = 1'b1;
    check("nf_busy", int'(busy), 0);
    rd(5, d);
    check("nf_rd_tap5", d, 6);

    // Shadow swap while streaming x=1.
    load_all(1);
    zeros(33);
    for (int n = 1; n <= 33; n++) smp_chk($sformatf("ramp1_%0d", n), 1, n);
    flag = 1'b1;
    tick();
    for (int k = 0; k < 33; k++) begin
      wr(k, 2);
      smp_chk("load_hold", 1, 33);
    end
    check("busy_during_load", int'(busy), 1);
    flag = 1'b0;
    tick();
    check("busy_pend2", int'(busy), 1);
    for (int n = 1; n <= 33; n++) begin
      smp_chk($sformatf("ramp2_%0d", n), 1, 33 + n);
      if (n == 1) check("busy_clear", int'(busy), 0);
    end

    // Large negative step: clamp or wrap depending on the build.
    load_all(16'h7FFF);
    zeros(33);
`ifdef FIR_OUT_SAT_EN
    smp_chk("sat1", -4, -32768);
    smp_chk("sat2", -4, -32768);
`else
    smp_chk("wrap1", -4, 4);
    smp_chk("wrap2", -4, 8);
`endif

    // Rounding on the two-tap instance.
    r_load(3);
    r_chk("rnd_6", 2, 2);
    r_chk("rnd_m9", -3, -2);
    r_load(1);
    r_chk("rnd_m2", -2, 0);
    r_chk("rnd_m3", -3, -1);
    r_chk("rnd_3", 3, 1);

    // Reset in the middle of a load.
    flag = 1'b1;
    tick();
    wr(0, 16'h0055);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", int'(fir_out), 0);
    check("mid_rst_valid", int'(valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_rd", int'(rdata), 0);
    tick();
    flag = 1'b0;
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", int'(busy), 0);
    for (int k = 0; k < 33; k++) begin
      rd(k, d);
      check($sformatf("post_rst_rd%0d", k), d, 0);
    end
    smp(3, y, vld);
    check("post_rst_out", y, 0);
    check("post_rst_busy2", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
